// File: rtl/life_pkg.sv
// Shared types and helpers for the Game-of-Life generation engine.
// Holds default board size, FSM state enum, board type and counter helper.
package life_pkg;

    localparam int ROWS_DEF = 16;
    localparam int COLS_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        COMMIT
    } life_state_t;

    typedef logic [ROWS_DEF-1:0][COLS_DEF-1:0] board_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/life_board_stepper_if.sv
// Control/status bundle of the life board stepper.
// master: trigger, run/step and seed inputs; slave: board and status outputs.
interface life_board_stepper_if #(
    parameter int ROWS = 16,
    parameter int COLS = 16
);
    localparam int RW = $clog2(ROWS);

    logic                       tick_en;
    logic                       run;
    logic                       step;
    logic                       seed_we;
    logic [RW-1:0]              seed_row;
    logic [COLS-1:0]            seed_data;
    logic [ROWS-1:0][COLS-1:0]  board_out;
    logic                       busy;
    logic [15:0]                gen_count;
    logic                       stable;
    logic                       extinct;

    modport master (
        output tick_en, run, step, seed_we, seed_row, seed_data,
        input  board_out, busy, gen_count, stable, extinct
    );

    modport slave (
        input  tick_en, run, step, seed_we, seed_row, seed_data,
        output board_out, busy, gen_count, stable, extinct
    );

endinterface

// File: rtl/life_cell_rule.sv
// Combinational Game-of-Life rule for one cell.
// Ports: top/mid/bot = 3x3 neighbourhood rows (mid[1] is the cell), next = new state.
module life_cell_rule (
    input  logic [2:0] top,
    input  logic [2:0] mid,
    input  logic [2:0] bot,
    output logic       next
);
    logic [3:0] n;

    always_comb begin
        n = 4'(top[0]) + 4'(top[1]) + 4'(top[2])
          + 4'(mid[0]) + 4'(mid[2])
          + 4'(bot[0]) + 4'(bot[1]) + 4'(bot[2]);
        next = (n == 4'd3) | (mid[1] & (n == 4'd2));
    end

endmodule

// File: rtl/life_board_stepper.sv
// Game-of-Life engine: one row per cycle into a shadow, then atomic commit.
// Ports: clk, reset (sync, active-high), bus (slave side of life_board_stepper_if).
module life_board_stepper
    import life_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF,
    parameter int WRAP = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    life_board_stepper_if.slave  bus
);
    localparam int RW = $clog2(ROWS);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    typedef logic [ROWS-1:0][COLS-1:0] brd_t;

    life_state_t     state;
    life_state_t     state_nx;
    logic [RW-1:0]   row_idx;
    brd_t            board;
    brd_t            shadow;
    logic [15:0]     gen_count;
    logic            stable;
    logic            extinct;

    logic            trigger;
    logic            seed_ok;
    logic [COLS-1:0] row_up;
    logic [COLS-1:0] row_mid;
    logic [COLS-1:0] row_dn;
    logic [COLS+1:0] ext_up;
    logic [COLS+1:0] ext_mid;
    logic [COLS+1:0] ext_dn;
    logic [COLS-1:0] row_next;

    // Bit 0 is column -1, bit COLS+1 is column COLS.
    function automatic logic [COLS+1:0] pad(input logic [COLS-1:0] r);
        if (WRAP != 0)
            return {r[0], r, r[COLS-1]};
        return {1'b0, r, 1'b0};
    endfunction

    assign trigger = (bus.tick_en & bus.run) | (bus.step & ~bus.run);
    assign seed_ok = int'({1'b0, bus.seed_row}) < ROWS;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // A seed write in IDLE takes priority over a same-cycle trigger.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (trigger && !bus.seed_we)
                    state_nx = COMPUTE;
            end
            COMPUTE: begin
                if (row_idx == LAST_ROW)
                    state_nx = COMMIT;
            end
            COMMIT: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Neighbour rows always come from the committed board.
    always_comb begin
        row_mid = board[row_idx];
        row_up  = '0;
        row_dn  = '0;
        if (row_idx != '0)
            row_up = board[row_idx - RW'(1)];
        else if (WRAP != 0)
            row_up = board[ROWS-1];
        if (row_idx != LAST_ROW)
            row_dn = board[row_idx + RW'(1)];
        else if (WRAP != 0)
            row_dn = board[0];
        ext_up  = pad(row_up);
        ext_mid = pad(row_mid);
        ext_dn  = pad(row_dn);
    end

    for (genvar c = 0; c < COLS; c++) begin : g_cell
        life_cell_rule u_rule (
            .top  (ext_up[c+2:c]),
            .mid  (ext_mid[c+2:c]),
            .bot  (ext_dn[c+2:c]),
            .next (row_next[c])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_idx   <= '0;
            board     <= '0;
            shadow    <= '0;
            gen_count <= '0;
            stable    <= 1'b0;
            extinct   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.seed_we) begin
                        if (seed_ok)
                            board[bus.seed_row] <= bus.seed_data;
                        gen_count <= '0;
                        stable    <= 1'b0;
                        extinct   <= 1'b0;
                    end else if (trigger) begin
                        row_idx <= '0;
                    end
                end
                COMPUTE: begin
                    shadow[row_idx] <= row_next;
                    row_idx         <= row_idx + RW'(1);
                end
                COMMIT: begin
                    board     <= shadow;
                    gen_count <= sat_inc(gen_count);
                    stable    <= (shadow == board);
                    extinct   <= (shadow == '0);
                end
                default: ;
            endcase
        end
    end

    assign bus.board_out = board;
    assign bus.busy      = (state != IDLE);
    assign bus.gen_count = gen_count;
    assign bus.stable    = stable;
    assign bus.extinct   = extinct;

endmodule

// File: tb/tb_life_board_stepper.sv
// Directed bench for life_board_stepper: two instances, WRAP=0 and WRAP=1.
// Both see identical stimulus; checks use immediate assertions.
module tb_life_board_stepper;

    localparam int ROWS = 16;
    localparam int COLS = 16;

    typedef logic [ROWS-1:0][COLS-1:0] brd_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick_en;
    logic        run;
    logic        step;
    logic        seed_we;
    logic [3:0]  seed_row;
    logic [15:0] seed_data;

    int   vectors = 0;
    int   miscompares = 0;
    int   busy_cycles;
    brd_t exp0;
    brd_t exp1;

    always #5 clk = ~clk;

    life_board_stepper_if #(.ROWS(ROWS), .COLS(COLS)) bus0 ();
    life_board_stepper_if #(.ROWS(ROWS), .COLS(COLS)) bus1 ();

    assign bus0.tick_en   = tick_en;
    assign bus0.run       = run;
    assign bus0.step      = step;
    assign bus0.seed_we   = seed_we;
    assign bus0.seed_row  = seed_row;
    assign bus0.seed_data = seed_data;
    assign bus1.tick_en   = tick_en;
    assign bus1.run       = run;
    assign bus1.step      = step;
    assign bus1.seed_we   = seed_we;
    assign bus1.seed_row  = seed_row;
    assign bus1.seed_data = seed_data;

    life_board_stepper #(.ROWS(ROWS), .COLS(COLS), .WRAP(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    life_board_stepper #(.ROWS(ROWS), .COLS(COLS), .WRAP(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    task automatic check(input string tag,
                         input logic [255:0] obs,
                         input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        edge1();
        edge1();
        reset = 1'b0;
    endtask

    task automatic seed(input logic [3:0] r, input logic [15:0] d);
        seed_we   = 1'b1;
        seed_row  = r;
        seed_data = d;
        edge1();
        seed_we   = 1'b0;
    endtask

    // Single step with run=0, then wait (bounded) for the commit.
    task automatic do_step();
        step = 1'b1;
        edge1();
        step = 1'b0;
        for (int k = 0; k < 40 && bus0.busy; k++)
            edge1();
        check("step_done", 256'(bus0.busy), 256'(0));
    endtask

    initial begin
        reset = 1'b1; tick_en = 1'b0; run = 1'b0; step = 1'b0;
        seed_we = 1'b0; seed_row = '0; seed_data = '0;
        do_reset();

        check("rst_board",   bus0.board_out, 256'(0));
        check("rst_busy",    256'(bus0.busy), 256'(0));
        check("rst_gen",     256'(bus0.gen_count), 256'(0));
        check("rst_stable",  256'(bus0.stable), 256'(0));
        check("rst_extinct", 256'(bus0.extinct), 256'(0));

        // Blinker
        seed(4'd7, 16'h01C0);
        do_step();
        exp0 = '0;
        exp0[6] = 16'h0080; exp0[7] = 16'h0080; exp0[8] = 16'h0080;
        check("blink1_board", bus0.board_out, exp0);
        check("blink1_gen", 256'(bus0.gen_count), 256'(1));
        check("blink1_stable", 256'(bus0.stable), 256'(0));
        do_step();
        exp0 = '0;
        exp0[7] = 16'h01C0;
        check("blink2_board", bus0.board_out, exp0);
        check("blink2_gen", 256'(bus0.gen_count), 256'(2));
        check("blink2_stable", 256'(bus0.stable), 256'(0));

        // Block in the corner
        do_reset();
        seed(4'd0, 16'h0003);
        seed(4'd1, 16'h0003);
        do_step();
        exp0 = '0;
        exp0[0] = 16'h0003; exp0[1] = 16'h0003;
        check("block_board", bus0.board_out, exp0);
        check("block_stable", 256'(bus0.stable), 256'(1));
        check("block_extinct", 256'(bus0.extinct), 256'(0));
        check("block_gen", 256'(bus0.gen_count), 256'(1));
        check("block_board_w", bus1.board_out, exp0);
        check("block_stable_w", 256'(bus1.stable), 256'(1));

        // Edge blinker across column 15/0
        do_reset();
        seed(4'd0, 16'h8003);
        do_step();
        check("edge_board", bus0.board_out, 256'(0));
        check("edge_extinct", 256'(bus0.extinct), 256'(1));
        exp1 = '0;
        exp1[15] = 16'h0001; exp1[0] = 16'h0001; exp1[1] = 16'h0001;
        check("edge_board_w", bus1.board_out, exp1);
        check("edge_extinct_w", 256'(bus1.extinct), 256'(0));

        // Timing: tick_en at E0, again at E0+3, seed at E0+5
        do_reset();
        seed(4'd0, 16'h0003);
        seed(4'd1, 16'h0003);
        run = 1'b1;
        tick_en = 1'b1;
        edge1();
        tick_en = 1'b0;
        busy_cycles = bus0.busy ? 1 : 0;
        check("tim_busy_e0", 256'(bus0.busy), 256'(1));
        for (int i = 1; i <= 25; i++) begin
            tick_en   = (i == 3);
            seed_we   = (i == 5);
            seed_row  = 4'd5;
            seed_data = 16'hFFFF;
            edge1();
            if (bus0.busy)
                busy_cycles++;
            if (i == 10)
                check("tim_mid_board", bus0.board_out, exp0);
        end
        tick_en = 1'b0;
        seed_we = 1'b0;
        run = 1'b0;
        check("tim_busy_cnt", 256'(busy_cycles), 256'(17));
        check("tim_gen", 256'(bus0.gen_count), 256'(1));
        check("tim_board", bus0.board_out, exp0);

        // Control: ignored triggers
        for (int i = 0; i < 3; i++) begin
            tick_en = 1'b1;
            edge1();
            tick_en = 1'b0;
            check("ctl_tick_paused", 256'(bus0.busy), 256'(0));
        end
        run = 1'b1;
        step = 1'b1;
        edge1();
        step = 1'b0;
        check("ctl_step_run", 256'(bus0.busy), 256'(0));
        check("ctl_gen_hold", 256'(bus0.gen_count), 256'(1));
        seed_we = 1'b1; seed_row = 4'd10; seed_data = 16'h00F0;
        tick_en = 1'b1;
        edge1();
        seed_we = 1'b0;
        tick_en = 1'b0;
        run = 1'b0;
        check("ctl_seed_busy", 256'(bus0.busy), 256'(0));
        exp0[10] = 16'h00F0;
        check("ctl_seed_board", bus0.board_out, exp0);
        check("ctl_seed_gen", 256'(bus0.gen_count), 256'(0));
        edge1();
        edge1();
        check("ctl_seed_idle", 256'(bus0.busy), 256'(0));

        // Reset during COMPUTE
        step = 1'b1;
        edge1();
        step = 1'b0;
        for (int i = 0; i < 5; i++)
            edge1();
        check("mid_busy", 256'(bus0.busy), 256'(1));
        reset = 1'b1;
        edge1();
        reset = 1'b0;
        check("mid_rst_board", bus0.board_out, 256'(0));
        check("mid_rst_busy", 256'(bus0.busy), 256'(0));
        check("mid_rst_gen", 256'(bus0.gen_count), 256'(0));
        edge1();
        check("mid_rst_idle", 256'(bus0.busy), 256'(0));
        do_step();
        check("empty_extinct", 256'(bus0.extinct), 256'(1));
        check("empty_gen", 256'(bus0.gen_count), 256'(1));
        check("empty_board", bus0.board_out, 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
